// File: rtl/layer_seq_ctrl.sv
// Layer scheduler: walks a host-written descriptor table, one LOAD/RUN/GAP pass per layer.
// Optional watchdog on RUN enabled by defining LAYER_TIMEOUT_EN.
module layer_seq_ctrl #(
  parameter int DEPTH   = 8,
  parameter int IDX_W   = 3,
  parameter int GAP_CYC = 4,
  parameter int DESC_W  = 109
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DESC_W-1:0] cfg_data,
  output logic              cfg_err,
  input  logic              start,
  input  logic [IDX_W:0]    num_layers,
  input  logic              abort,
  input  logic              layer_done,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              timeout,
  output logic [IDX_W-1:0]  layer_idx,
  output logic              run,
  output logic              backprop,
  output logic              deltaw,
  output logic              enbias,
  output logic              last,
  output logic [3:0]        dd,
  output logic [3:0]        id,
  output logic [3:0]        od,
  output logic [9:0]        is,
  output logic [9:0]        os,
  output logic [9:0]        fs,
  output logic [9:0]        ks,
  output logic [4:0]        ih,
  output logic [4:0]        iw,
  output logic [4:0]        oh,
  output logic [4:0]        ow,
  output logic [4:0]        kh,
  output logic [4:0]        kw,
  output logic [11:0]       ss,
  output logic [11:0]       ds
);

  typedef struct packed {
    logic        backprop;
    logic        deltaw;
    logic        enbias;
    logic [3:0]  dd;
    logic [3:0]  id;
    logic [9:0]  is_f;
    logic [4:0]  ih;
    logic [4:0]  iw;
    logic [3:0]  od;
    logic [9:0]  os;
    logic [4:0]  oh;
    logic [4:0]  ow;
    logic [9:0]  fs;
    logic [9:0]  ks;
    logic [4:0]  kh;
    logic [4:0]  kw;
    logic [11:0] ss;
    logic [11:0] ds;
  } desc_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   num_q, num_d;
  logic [7:0]       gap_q, gap_d;
  logic             abrt_q, abrt_d;
  logic             tmo_q, tmo_d;
  logic             run_q, run_d;
  logic             last_q;
  logic             cfg_err_q;
  logic             load_en;
  logic             busy_w;
  logic             wd_hit;
  desc_t            desc_q;
  desc_t            mem [DEPTH];

  assign busy_w = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_GAP);

  // Writes are only accepted between jobs so a running job never sees a torn table.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy_w) mem[cfg_idx] <= cfg_data;
  end

`ifdef LAYER_TIMEOUT_EN
  logic [23:0] wd_q, wd_d;
  always_comb begin
    wd_d = wd_q;
    if (load_en) wd_d = '0;
    else if (state_q == S_RUN && wd_q != '1) wd_d = wd_q + 24'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
  assign wd_hit = (state_q == S_RUN) && (wd_q == '1);
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      abrt_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      gap_q   <= gap_d;
      abrt_q  <= abrt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    gap_d   = gap_q;
    abrt_d  = abrt_q;
    tmo_d   = tmo_q;
    load_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = num_layers;
          idx_d   = '0;
          abrt_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = (num_layers == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        load_en = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        // The first RUN cycle is a setup cycle with run still low; done is only honoured once run is up.
        if (run_q && layer_done) begin
          state_d = S_GAP;
          gap_d   = '0;
        end else if (wd_hit) begin
          state_d = S_FIN;
          abrt_d  = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == 8'(GAP_CYC - 1)) begin
          if (last_q) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (busy_w && abort) begin
      state_d = S_FIN;
      abrt_d  = 1'b1;
    end
  end

  assign run_d = (state_q == S_RUN) && (state_d == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_q    <= '0;
      last_q    <= 1'b0;
      run_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      cfg_err_q <= cfg_we && busy_w;
      if (load_en) begin
        desc_q <= mem[idx_q];
        last_q <= ({1'b0, idx_q} == (num_q - 1'b1));
      end
      // Later assignments win: an abort during LOAD still leaves the strobes cleared.
      if (state_d == S_FIN) begin
        desc_q.backprop <= 1'b0;
        desc_q.deltaw   <= 1'b0;
        desc_q.enbias   <= 1'b0;
        last_q          <= 1'b0;
      end
    end
  end

  assign cfg_err   = cfg_err_q;
  assign busy      = busy_w;
  assign done      = (state_q == S_FIN);
  assign aborted   = done && abrt_q;
  assign timeout   = done && tmo_q;
  assign layer_idx = idx_q;
  assign run       = run_q;
  assign last      = last_q;
  assign backprop  = desc_q.backprop;
  assign deltaw    = desc_q.deltaw;
  assign enbias    = desc_q.enbias;
  assign dd        = desc_q.dd;
  assign id        = desc_q.id;
  assign is        = desc_q.is_f;
  assign ih        = desc_q.ih;
  assign iw        = desc_q.iw;
  assign od        = desc_q.od;
  assign os        = desc_q.os;
  assign oh        = desc_q.oh;
  assign ow        = desc_q.ow;
  assign fs        = desc_q.fs;
  assign ks        = desc_q.ks;
  assign kh        = desc_q.kh;
  assign kw        = desc_q.kw;
  assign ss        = desc_q.ss;
  assign ds        = desc_q.ds;

endmodule
